mips_pipe_control: RTL
======================

# mips_pipe_control

Pipelined successor to the combinational MIPS decoder. It decodes opcode/function in ID into the 18-bit control word and carries control plus destination register through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble), applies branch/jump flushes, and produces EX-stage forwarding selects. Sits between the IF/ID register and the datapath of the 5-stage core.

## Interface
- NB_FUNCTION, 6, opcode/function width
- NB_CONTROL, 18, control word width; field map fixed in package
- NB_REG, 5, register index width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high
- i_enable  in  1  pipeline advance; low holds every stage register (debug step)
- i_flush  in  1  branch/jump taken; squashes the instruction currently in ID
- i_operation, i_function  in  NB_FUNCTION  ID-stage opcode / funct
- i_rs, i_rt, i_rd  in  NB_REG  ID-stage register fields
- o_ctrl_ex, o_ctrl_mem, o_ctrl_wb  out  NB_CONTROL  registered control word per stage
- o_dst_ex, o_dst_mem, o_dst_wb  out  NB_REG  registered destination register per stage
- o_stall  out  1  combinational; hold PC and IF/ID
- o_fwd_a, o_fwd_b  out  2  combinational EX operand select: 00 register file, 10 EX/MEM, 01 MEM/WB

## Operation
- Field map, MSB to LSB: RegDst, MemToReg, MemRead, Branch, MemWrite, AluOp[2:0], ALUSrc, RegWrite, ShiftSrc, JmpSrc, JReturnDst, EQorNE, DataMask[1:0], IsUnsigned, JmpOrBrch.
- Decode classes, in priority order:
  - load: op 1?0??? gives MemRead=1, RegWrite=1, RegDst=0.
  - store: op 1?1??? gives MemWrite=1, RegWrite=0.
  - imm-ALU: op 0?1??? gives RegWrite=1, RegDst=0.
  - branch: op 0?01?? gives Branch=1, RegWrite=0.
  - J/JAL: op 0?001? gives RegWrite=op[0], JReturnDst=1.
  - JR/JALR: op 000000 with funct 001??? gives RegWrite=funct[0].
  - all else is R-type: RegDst=1, RegWrite=1, AluOp=001.
- Destination register: 31 if JReturnDst and RegWrite; rd if RegDst; otherwise rt.
- EX stage also registers rs_ex and rt_ex internally.
- o_stall=1 when all of the following hold:
  - o_ctrl_ex MemRead=1;
  - o_dst_ex≠0;
  - o_dst_ex equals i_rs, or equals i_rt for a class that reads rt (store, branch, R-type).
- Forwarding for operand A, evaluated on rs_ex:
  - 10 when EX/MEM RegWrite=1, o_dst_mem≠0 and o_dst_mem==rs_ex;
  - else 01 under the same test on the WB stage;
  - else 00.
  - EX/MEM always has priority over MEM/WB.
- Forwarding for operand B uses the same rules on rt_ex.
- Register 0 is never a hazard source or a forward source.
- Per-edge priority when loading ID/EX:
  1. reset: all stage registers become 0.
  2. i_enable=0: all stages hold.
  3. i_flush or o_stall: ID/EX loads a bubble (control 0, dst 0).
  4. otherwise ID/EX loads the decoded word.
- EX/MEM and MEM/WB always shift when i_enable=1.
- o_stall and o_fwd_* are forced to 0 while i_enable=0.

## Timing
- Reset value: every o_ctrl_*, o_dst_* is 0.
- Reset value: o_stall and o_fwd_* are 0, because no stage holds a writer.
- Decode-to-o_ctrl_ex latency: 1 cycle; o_ctrl_mem +2; o_ctrl_wb +3.
- Load-use dependence: exactly one stall cycle.
  - Cycle N: load in EX, dependent instruction in ID, o_stall=1.
  - Cycle N+1: bubble in EX, load in MEM, o_stall=0, dependent instruction re-decoded.
  - Cycle N+2: dependent instruction in EX with o_fwd=01.
- Simultaneous flush and stall: a single bubble; the stalled instruction is the one being squashed.
- Reset asserted mid-stall clears all stages on the next edge.

## Structure
- Package mips_ctrl_pkg holds:
  - field index localparams (CTRL_REGDST … CTRL_JMPORBRCH);
  - forwarding select constants FWD_RF, FWD_MEM, FWD_WB;
  - the decode function.
- Sub-module mips_ctrl_decode: combinational decode plus destination-register select, instantiated once in ID.
- Top module holds the stage registers, hazard compare and forwarding compare.

## Test plan
- Reset: assert i_reset for 2 cycles → all outputs 0.
- R-type flow: ADD rd=3, rs=1, rt=2 → o_ctrl_ex RegDst=1, RegWrite=1; o_dst_ex=3; o_dst_wb=3 three cycles later.
- Back-to-back ALU ops:
  - ADD r3 followed by SUB rs=3 → o_fwd_a=10 at SUB's EX.
  - Insert a NOP between the two instead → o_fwd_a=01.
  - Same pair with dst r0 → o_fwd_a=00.
- Load-use: LW r5 then ADD rs=5 → o_stall=1 for one cycle; bubble (0) in o_ctrl_ex; ADD reaches EX with o_fwd_a=01.
- Flush: i_flush with BEQ in ID → o_ctrl_ex=0 next cycle. i_flush together with o_stall → single bubble.
- Enable hold: drop i_enable for 3 cycles mid-stream → all o_ctrl_*/o_dst_* frozen and o_stall=0; the stream resumes unchanged.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - control word field map, forwarding selects and ID decode function
package mips_ctrl_pkg;
  localparam int OP_W   = 6;
  localparam int CTRL_W = 18;
  localparam int REG_W  = 5;

  localparam int CTRL_REGDST     = 17;
  localparam int CTRL_MEMTOREG   = 16;
  localparam int CTRL_MEMREAD    = 15;
  localparam int CTRL_BRANCH     = 14;
  localparam int CTRL_MEMWRITE   = 13;
  localparam int CTRL_ALUOP      = 12;
  localparam int CTRL_ALUSRC     = 9;
  localparam int CTRL_REGWRITE   = 8;
  localparam int CTRL_SHIFTSRC   = 7;
  localparam int CTRL_JMPSRC     = 6;
  localparam int CTRL_JRETURNDST = 5;
  localparam int CTRL_EQORNE     = 4;
  localparam int CTRL_DATAMASK   = 3;
  localparam int CTRL_ISUNSIGNED = 1;
  localparam int CTRL_JMPORBRCH  = 0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [2:0] {
    CLS_LOAD, CLS_STORE, CLS_IMM, CLS_BRANCH, CLS_JUMP, CLS_JREG, CLS_RTYPE
  } cls_e;

  function automatic cls_e decode_class(input logic [OP_W-1:0] op, input logic [OP_W-1:0] funct);
    cls_e c;
    casez (op)
      6'b1?0???: c = CLS_LOAD;
      6'b1?1???: c = CLS_STORE;
      6'b0?1???: c = CLS_IMM;
      6'b0?01??: c = CLS_BRANCH;
      6'b0?001?: c = CLS_JUMP;
      default:   c = (op == 6'd0 && funct[5:3] == 3'b001) ? CLS_JREG : CLS_RTYPE;
    endcase
    return c;
  endfunction

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [OP_W-1:0] op, input logic [OP_W-1:0] funct);
    logic [CTRL_W-1:0] w;
    w = '0;
    case (decode_class(op, funct))
      CLS_LOAD: begin
        w[CTRL_MEMTOREG] = 1'b1;
        w[CTRL_MEMREAD]  = 1'b1;
        w[CTRL_ALUSRC]   = 1'b1;
        w[CTRL_REGWRITE] = 1'b1;
        w[CTRL_DATAMASK -: 2] = op[1:0];
        w[CTRL_ISUNSIGNED]    = op[2];
      end
      CLS_STORE: begin
        w[CTRL_MEMWRITE] = 1'b1;
        w[CTRL_ALUSRC]   = 1'b1;
        w[CTRL_DATAMASK -: 2] = op[1:0];
      end
      CLS_IMM: begin
        w[CTRL_ALUSRC]   = 1'b1;
        w[CTRL_REGWRITE] = 1'b1;
        w[CTRL_ALUOP -: 3]    = 3'b010;
        w[CTRL_ISUNSIGNED]    = op[0];
      end
      CLS_BRANCH: begin
        w[CTRL_BRANCH]    = 1'b1;
        w[CTRL_EQORNE]    = op[0];
        w[CTRL_JMPORBRCH] = 1'b1;
        w[CTRL_ALUOP -: 3] = 3'b011;
      end
      CLS_JUMP: begin
        w[CTRL_REGWRITE]   = op[0];
        w[CTRL_JRETURNDST] = 1'b1;
        w[CTRL_JMPORBRCH]  = 1'b1;
      end
      CLS_JREG: begin
        w[CTRL_REGWRITE]  = funct[0];
        w[CTRL_REGDST]    = funct[0];
        w[CTRL_JMPSRC]    = 1'b1;
        w[CTRL_JMPORBRCH] = 1'b1;
      end
      default: begin
        w[CTRL_REGDST]   = 1'b1;
        w[CTRL_REGWRITE] = 1'b1;
        w[CTRL_ALUOP -: 3] = 3'b001;
        w[CTRL_SHIFTSRC] = (funct[5:2] == 4'b0000);
      end
    endcase
    return w;
  endfunction
endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - ID-stage control decode and destination register select
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   i_operation,
  input  logic [OP_W-1:0]   i_function,
  input  logic [REG_W-1:0]  i_rt,
  input  logic [REG_W-1:0]  i_rd,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [REG_W-1:0]  o_dst,
  output logic              o_reads_rt
);
  cls_e w_cls;

  always_comb begin
    w_cls      = decode_class(i_operation, i_function);
    o_ctrl     = decode_ctrl(i_operation, i_function);
    o_reads_rt = (w_cls == CLS_STORE) || (w_cls == CLS_BRANCH) || (w_cls == CLS_RTYPE);
    if (o_ctrl[CTRL_JRETURNDST] && o_ctrl[CTRL_REGWRITE])
      o_dst = 5'd31;
    else if (o_ctrl[CTRL_REGDST])
      o_dst = i_rd;
    else
      o_dst = i_rt;
  end
endmodule

// File: rtl/mips_pipe_control.sv
// rtl/mips_pipe_control.sv - pipelined control: ID/EX, EX/MEM, MEM/WB registers, load-use stall, forwarding
module mips_pipe_control
  import mips_ctrl_pkg::*;
#(
  parameter int NB_FUNCTION = 6,
  parameter int NB_CONTROL  = 18,
  parameter int NB_REG      = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic [NB_FUNCTION-1:0] i_operation,
  input  logic [NB_FUNCTION-1:0] i_function,
  input  logic [NB_REG-1:0]      i_rs,
  input  logic [NB_REG-1:0]      i_rt,
  input  logic [NB_REG-1:0]      i_rd,
  output logic [NB_CONTROL-1:0]  o_ctrl_ex,
  output logic [NB_CONTROL-1:0]  o_ctrl_mem,
  output logic [NB_CONTROL-1:0]  o_ctrl_wb,
  output logic [NB_REG-1:0]      o_dst_ex,
  output logic [NB_REG-1:0]      o_dst_mem,
  output logic [NB_REG-1:0]      o_dst_wb,
  output logic                   o_stall,
  output logic [1:0]             o_fwd_a,
  output logic [1:0]             o_fwd_b
);
  logic [NB_CONTROL-1:0] w_ctrl_id;
  logic [NB_REG-1:0]     w_dst_id;
  logic                  w_reads_rt;
  logic [NB_CONTROL-1:0] r_ctrl_ex, r_ctrl_mem, r_ctrl_wb;
  logic [NB_REG-1:0]     r_dst_ex, r_dst_mem, r_dst_wb;
  logic [NB_REG-1:0]     r_rs_ex, r_rt_ex;
  logic                  w_bubble;

  mips_ctrl_decode u_decode (
    .i_operation (i_operation),
    .i_function  (i_function),
    .i_rt        (i_rt),
    .i_rd        (i_rd),
    .o_ctrl      (w_ctrl_id),
    .o_dst       (w_dst_id),
    .o_reads_rt  (w_reads_rt)
  );

  function automatic logic [1:0] fwd_sel(input logic [NB_REG-1:0] src);
    if (r_ctrl_mem[CTRL_REGWRITE] && r_dst_mem != '0 && r_dst_mem == src)
      return FWD_MEM;
    else if (r_ctrl_wb[CTRL_REGWRITE] && r_dst_wb != '0 && r_dst_wb == src)
      return FWD_WB;
    return FWD_RF;
  endfunction

  // Hazard and forward outputs are suppressed while the pipeline is frozen.
  always_comb begin
    o_stall = i_enable && r_ctrl_ex[CTRL_MEMREAD] && (r_dst_ex != '0) &&
              ((r_dst_ex == i_rs) || (w_reads_rt && r_dst_ex == i_rt));
    o_fwd_a = i_enable ? fwd_sel(r_rs_ex) : FWD_RF;
    o_fwd_b = i_enable ? fwd_sel(r_rt_ex) : FWD_RF;
  end

  assign w_bubble = i_flush || o_stall;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ctrl_ex  <= '0;
      r_ctrl_mem <= '0;
      r_ctrl_wb  <= '0;
      r_dst_ex   <= '0;
      r_dst_mem  <= '0;
      r_dst_wb   <= '0;
      r_rs_ex    <= '0;
      r_rt_ex    <= '0;
    end else if (i_enable) begin
      r_ctrl_ex  <= w_bubble ? '0 : w_ctrl_id;
      r_dst_ex   <= w_bubble ? '0 : w_dst_id;
      r_rs_ex    <= w_bubble ? '0 : i_rs;
      r_rt_ex    <= w_bubble ? '0 : i_rt;
      r_ctrl_mem <= r_ctrl_ex;
      r_dst_mem  <= r_dst_ex;
      r_ctrl_wb  <= r_ctrl_mem;
      r_dst_wb   <= r_dst_mem;
    end
  end

  assign o_ctrl_ex  = r_ctrl_ex;
  assign o_ctrl_mem = r_ctrl_mem;
  assign o_ctrl_wb  = r_ctrl_wb;
  assign o_dst_ex   = r_dst_ex;
  assign o_dst_mem  = r_dst_mem;
  assign o_dst_wb   = r_dst_wb;
endmodule
